instr_seq: RTL and testbench

Instruction sequencer: the read-side controller for the instruction buffer in `instr_dec`. After a host `go`, it pops instructions one at a time and inspects each instruction's `start`/`last` flags. For an instruction with `start` set, it fires the matmul engine and waits for the engine's completion. It ends the program on the instruction flagged `last` and reports completion or timeout to the host.

---
 rtl/instr_seq_pkg.sv | 23 ++
 rtl/instr_seq_if.sv | 32 +++
 rtl/instr_seq.sv | 139 +++++++++++++
 tb/tb_instr_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared configuration for the instruction sequencer: state encoding and
// default parameter values.
package instr_seq_pkg;

    // Width of one instruction word in the instr_dec buffer.
    localparam int INSTR_SIZE = 32;

    // Default values for the sequencer parameters.
    localparam int RD_LAT_DEF = 1;
    localparam int TO_W_DEF   = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        POP,
        SETTLE,
        DONE
    } seq_state_e;

endpackage

// File: rtl/instr_seq_if.sv
// Host, instruction-buffer and engine signals of the instruction sequencer.
// The master side drives the sequencer inputs; the slave side is the sequencer.
interface instr_seq_if
    import instr_seq_pkg::*;
#(
    parameter int TO_W  = TO_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             go;
    logic [TO_W-1:0]  timeout;
    logic             instr_valid;
    logic             start;
    logic             last;
    logic             mm_done;
    logic             rd_nxt_inst;
    logic             mm_start;
    logic             busy;
    logic             prog_done;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] skipped_cnt;

    modport master (
        output go, timeout, instr_valid, start, last, mm_done,
        input  rd_nxt_inst, mm_start, busy, prog_done, err, issued_cnt, skipped_cnt
    );

    modport slave (
        input  go, timeout, instr_valid, start, last, mm_done,
        output rd_nxt_inst, mm_start, busy, prog_done, err, issued_cnt, skipped_cnt
    );
endinterface

// File: rtl/instr_seq.sv
// Instruction sequencer: pops instructions from instr_dec, fires the matmul
// engine for instructions with start set, waits for completion (with an
// optional timeout) and ends the program on the instruction flagged last.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int TO_W   = TO_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    instr_seq_if.slave bus
);
    // Settle counter spans RD_LAT cycles after a pop (loaded with RD_LAT-1).
    localparam int               SET_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [SET_W-1:0] SET_INIT = SET_W'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

    seq_state_e       state, state_d;
    logic             last_q;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_nxt;
    logic             to_expire;
    logic [SET_W-1:0] settle_cnt;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] skipped_cnt;
    logic             err_q;
    logic             clr_run;
    logic             skip_inc;
    logic             iss_inc;
    logic             set_err;

    assign to_nxt    = to_cnt + 1'b1;
    assign to_expire = (bus.timeout != '0) && (to_nxt == bus.timeout);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state decode and per-cycle counter/flag strobes.
    always_comb begin
        state_d  = state;
        clr_run  = 1'b0;
        skip_inc = 1'b0;
        iss_inc  = 1'b0;
        set_err  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.go) begin
                    clr_run = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.instr_valid) begin
                    if (bus.start) begin
                        state_d = ISSUE;
                    end else begin
                        skip_inc = 1'b1;
                        state_d  = POP;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Completion wins over a timeout expiring in the same cycle.
                if (bus.mm_done) begin
                    iss_inc = 1'b1;
                    state_d = POP;
                end else if (to_expire) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end
            end
            POP: begin
                if (last_q)           state_d = DONE;
                else if (RD_LAT == 0) state_d = FETCH;
                else                  state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) state_d = FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the last flag of the instruction accepted in FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   last_q <= 1'b0;
        else if (state == FETCH && bus.instr_valid) last_q <= bus.last;
    end

    // Wait-timeout counter: cleared on issue, counts WAIT cycles when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                     to_cnt <= '0;
        else if (state == ISSUE)                                     to_cnt <= '0;
        else if (state == WAIT && !bus.mm_done && bus.timeout != '0) to_cnt <= to_nxt;
    end

    // Settle down-counter covering the buffer read latency after a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    settle_cnt <= '0;
        else if (state == POP)                      settle_cnt <= SET_INIT;
        else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
    end

    // Saturating count of executed instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              issued_cnt <= '0;
        else if (clr_run)                     issued_cnt <= '0;
        else if (iss_inc && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
    end

    // Saturating count of instructions popped without execution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                skipped_cnt <= '0;
        else if (clr_run)                       skipped_cnt <= '0;
        else if (skip_inc && skipped_cnt != '1) skipped_cnt <= skipped_cnt + 1'b1;
    end

    // Sticky timeout flag, cleared when a new program is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (clr_run) err_q <= 1'b0;
        else if (set_err) err_q <= 1'b1;
    end

    assign bus.rd_nxt_inst = (state == POP);
    assign bus.mm_start    = (state == ISSUE);
    assign bus.busy        = (state != IDLE);
    assign bus.prog_done   = (state == DONE);
    assign bus.err         = err_q;
    assign bus.issued_cnt  = issued_cnt;
    assign bus.skipped_cnt = skipped_cnt;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: a cycle-level vector table for the basic
// state walk, plus program runs against a small buffer/engine model.
module tb_instr_seq;

    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_seq_if #(.TO_W(16), .CNT_W(8)) bus ();

    instr_seq #(.RD_LAT(RD_LAT), .TO_W(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One table row: inputs for a cycle and the outputs expected after the edge.
    typedef struct {
        logic       go;
        logic       vld;
        logic       st;
        logic       ls;
        logic       dn;
        logic [4:0] exp_o;   // {busy, mm_start, rd_nxt_inst, prog_done, err}
        int         exp_iss;
        int         exp_skp;
    } vec_t;

    function automatic vec_t mk(input logic go, input logic vld, input logic st,
                                input logic ls, input logic dn, input logic [4:0] o,
                                input int iss, input int skp);
        vec_t v;
        v.go = go; v.vld = vld; v.st = st; v.ls = ls; v.dn = dn;
        v.exp_o = o; v.exp_iss = iss; v.exp_skp = skp;
        return v;
    endfunction

    function automatic int outs();
        return int'({bus.busy, bus.mm_start, bus.rd_nxt_inst, bus.prog_done, bus.err});
    endfunction

    task automatic idle_inputs();
        bus.go          = 1'b0;
        bus.instr_valid = 1'b0;
        bus.start       = 1'b0;
        bus.last        = 1'b0;
        bus.mm_done     = 1'b0;
    endtask

    // Program model shared with run_prog.
    int   prog_n;
    logic prog_s [300];
    logic prog_l [300];

    int   r_mstart, r_pop, r_done, r_mstart_cyc, r_done_cyc, r_stall_bad;
    logic r_err_at_done, r_err_after_go;

    // Kick a program and service the buffer and engine until prog_done.
    // eng_dly: cycles from mm_start to mm_done (0 = engine never answers).
    task automatic run_prog(input int eng_dly, input int stall_cyc);
        int idx   = 0;
        int stale = 0;
        int eng   = 0;
        int cyc   = 0;
        int stall = stall_cyc;
        r_mstart = 0; r_pop = 0; r_done = 0; r_stall_bad = 0;
        r_mstart_cyc = -1; r_done_cyc = -1; r_err_at_done = 1'bx;
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        r_err_after_go = bus.err;
        while (r_done == 0 && cyc < 2000) begin
            bus.mm_done = 1'b0;
            if (eng > 0) begin
                eng--;
                if (eng == 0) bus.mm_done = 1'b1;
            end
            if (bus.mm_start) begin
                r_mstart++;
                r_mstart_cyc = cyc;
                if (eng_dly > 0) eng = eng_dly;
            end
            if (stale > 0) stale--;
            if (bus.rd_nxt_inst) begin
                r_pop++;
                idx++;
                stale = RD_LAT;
            end
            if (bus.prog_done) begin
                r_done++;
                r_done_cyc    = cyc;
                r_err_at_done = bus.err;
            end
            if (stall > 0) begin
                stall--;
                if (!bus.busy || bus.mm_start || bus.rd_nxt_inst || bus.prog_done)
                    r_stall_bad++;
                bus.instr_valid = 1'b0;
            end else begin
                bus.instr_valid = (idx < prog_n) && (stale == 0);
            end
            bus.start = (idx < prog_n) ? prog_s[idx] : 1'b0;
            bus.last  = (idx < prog_n) ? prog_l[idx] : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        // Watch for stray pulses after the program ended.
        for (int k = 0; k < 5; k++) begin
            if (bus.mm_start)    r_mstart++;
            if (bus.rd_nxt_inst) r_pop++;
            if (bus.prog_done)   r_done++;
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl [20];

    initial begin
        idle_inputs();
        bus.timeout = '0;

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", outs(), 0);
        chk("reset cnts", int'({bus.issued_cnt, bus.skipped_cnt}), 0);
        rst = 1'b0;

        // Vector table: skip + issue program, spurious mm_done, go while busy.
        tbl[0]  = mk(1, 0, 0, 0, 0, 5'b10000, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 5'b10100, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 5'b10000, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 5'b10000, 0, 1);
        tbl[4]  = mk(0, 1, 1, 1, 0, 5'b11000, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 5'b10000, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 5'b10100, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 5'b10010, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 5'b00000, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 1, 5'b00000, 1, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 5'b10000, 0, 0);
        tbl[11] = mk(0, 1, 1, 0, 0, 5'b11000, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 5'b10000, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 5'b10000, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 5'b10100, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 5'b10000, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 5'b10000, 1, 0);
        tbl[17] = mk(0, 1, 0, 1, 0, 5'b10100, 1, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 5'b10010, 1, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 5'b00000, 1, 1);
        for (int i = 0; i < 20; i++) begin
            bus.go          = tbl[i].go;
            bus.instr_valid = tbl[i].vld;
            bus.start       = tbl[i].st;
            bus.last        = tbl[i].ls;
            bus.mm_done     = tbl[i].dn;
            @(posedge clk); #1;
            chk($sformatf("vec%0d outs", i), outs(), int'(tbl[i].exp_o));
            chk($sformatf("vec%0d cnts", i), int'({bus.issued_cnt, bus.skipped_cnt}),
                tbl[i].exp_iss * 256 + tbl[i].exp_skp);
        end
        idle_inputs();

        // Three issued instructions, engine answers 5 cycles after each fire.
        prog_n = 3;
        prog_s[0] = 1; prog_l[0] = 0;
        prog_s[1] = 1; prog_l[1] = 0;
        prog_s[2] = 1; prog_l[2] = 1;
        run_prog(5, 0);
        chk("p3 mm_start", r_mstart, 3);
        chk("p3 pops", r_pop, 3);
        chk("p3 prog_done", r_done, 1);
        chk("p3 issued", int'(bus.issued_cnt), 3);
        chk("p3 err", int'(r_err_at_done), 0);

        // Skipped first instruction, then an issued last one.
        prog_n = 2;
        prog_s[0] = 0; prog_l[0] = 0;
        prog_s[1] = 1; prog_l[1] = 1;
        run_prog(5, 0);
        chk("skip mm_start", r_mstart, 1);
        chk("skip pops", r_pop, 2);
        chk("skip skipped", int'(bus.skipped_cnt), 1);
        chk("skip issued", int'(bus.issued_cnt), 1);

        // Buffer empty for 20 cycles in FETCH.
        prog_n = 1;
        prog_s[0] = 1; prog_l[0] = 1;
        run_prog(3, 20);
        chk("stall quiet", r_stall_bad, 0);
        chk("stall mm_start cycle", r_mstart_cyc, 21);
        chk("stall pops", r_pop, 1);
        chk("stall prog_done", r_done, 1);

        // Engine never answers: timeout after 10 WAIT cycles.
        bus.timeout = 16'd10;
        run_prog(0, 0);
        chk("to done latency", r_done_cyc - r_mstart_cyc, 11);
        chk("to err at done", int'(r_err_at_done), 1);
        chk("to pops", r_pop, 0);
        chk("to err sticky", int'(bus.err), 1);
        chk("to issued", int'(bus.issued_cnt), 0);

        // Next go clears err; completion before expiry.
        run_prog(3, 0);
        chk("clr err after go", int'(r_err_after_go), 0);
        chk("clr err at done", int'(r_err_at_done), 0);
        chk("clr pops", r_pop, 1);

        // mm_done on the expiry cycle counts as completion.
        run_prog(10, 0);
        chk("edge pops", r_pop, 1);
        chk("edge err", int'(r_err_at_done), 0);
        chk("edge issued", int'(bus.issued_cnt), 1);

        // mm_done one cycle too late: timeout wins.
        run_prog(11, 0);
        chk("late pops", r_pop, 0);
        chk("late err", int'(r_err_at_done), 1);
        bus.timeout = '0;

        // Skipped counter saturates at 255.
        prog_n = 260;
        for (int i = 0; i < 260; i++) begin
            prog_s[i] = 1'b0;
            prog_l[i] = (i == 259);
        end
        run_prog(5, 0);
        chk("sat pops", r_pop, 260);
        chk("sat skipped", int'(bus.skipped_cnt), 255);
        chk("sat prog_done", r_done, 1);

        // Asynchronous reset during WAIT.
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        bus.instr_valid = 1'b1; bus.start = 1'b0; bus.last = 1'b0;
        @(posedge clk); #1;                 // POP
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;                 // SETTLE
        @(posedge clk); #1;                 // FETCH
        bus.instr_valid = 1'b1; bus.start = 1'b1; bus.last = 1'b1;
        @(posedge clk); #1;                 // ISSUE
        idle_inputs();
        @(posedge clk); #1;                 // WAIT
        @(posedge clk); #1;                 // WAIT
        chk("pre-rst busy", int'(bus.busy), 1);
        chk("pre-rst skipped", int'(bus.skipped_cnt), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst outs", outs(), 0);
        chk("rst cnts", int'({bus.issued_cnt, bus.skipped_cnt}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean run after reset.
        prog_n = 3;
        prog_s[0] = 1; prog_l[0] = 0;
        prog_s[1] = 1; prog_l[1] = 0;
        prog_s[2] = 1; prog_l[2] = 1;
        run_prog(5, 0);
        chk("post-rst issued", int'(bus.issued_cnt), 3);
        chk("post-rst skipped", int'(bus.skipped_cnt), 0);
        chk("post-rst prog_done", r_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
